// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction memory address
// and fills the IF/ID pipeline register, honouring stall, flush and redirect.
module fetch_stage #(
    parameter logic [15:0] RESET_PC        = 16'h0000,
    parameter logic [31:0] NOP_INSTRUCTION = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic [15:0] o_instruction_address,
    input  logic [31:0] i_instruction_data,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_branch_taken,
    input  logic [15:0] i_branch_target,
    output logic [31:0] o_if_id_instruction,
    output logic [15:0] o_if_id_pc,
    output logic        o_if_id_valid,
    output logic [15:0] o_fetch_count
);

    logic [15:0] pc_reg,          pc_next;
    logic [31:0] if_id_instr_reg, if_id_instr_next;
    logic [15:0] if_id_pc_reg,    if_id_pc_next;
    logic        if_id_valid_reg, if_id_valid_next;
    logic [15:0] count_reg,       count_next;

    always_comb begin
        pc_next          = pc_reg;
        if_id_instr_next = if_id_instr_reg;
        if_id_pc_next    = if_id_pc_reg;
        if_id_valid_next = if_id_valid_reg;
        count_next       = count_reg;

        if (i_branch_taken) begin
            // Redirect wins over stall and flush; the in-flight word is squashed.
            pc_next          = i_branch_target;
            if_id_instr_next = NOP_INSTRUCTION;
            if_id_pc_next    = 16'h0000;
            if_id_valid_next = 1'b0;
        end else if (i_flush) begin
            if_id_instr_next = NOP_INSTRUCTION;
            if_id_pc_next    = 16'h0000;
            if_id_valid_next = 1'b0;
            if (!i_stall) begin
                pc_next = pc_reg + 16'd1;
            end
        end else if (!i_stall) begin
            if_id_instr_next = i_instruction_data;
            if_id_pc_next    = pc_reg;
            if_id_valid_next = 1'b1;
            pc_next          = pc_reg + 16'd1;
            if (count_reg != 16'hFFFF) begin
                count_next = count_reg + 16'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pc_reg          <= RESET_PC;
            if_id_instr_reg <= NOP_INSTRUCTION;
            if_id_pc_reg    <= 16'h0000;
            if_id_valid_reg <= 1'b0;
            count_reg       <= 16'h0000;
        end else begin
            pc_reg          <= pc_next;
            if_id_instr_reg <= if_id_instr_next;
            if_id_pc_reg    <= if_id_pc_next;
            if_id_valid_reg <= if_id_valid_next;
            count_reg       <= count_next;
        end
    end

    assign o_instruction_address = pc_reg;
    assign o_if_id_instruction   = if_id_instr_reg;
    assign o_if_id_pc            = if_id_pc_reg;
    assign o_if_id_valid         = if_id_valid_reg;
    assign o_fetch_count         = count_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory word[k] = A000_0000 + k; a second
// instance with RESET_PC = 16'h0100 covers the overridden reset vector.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        branch = 1'b0;
    logic [15:0] target = 16'h0000;
    logic [15:0] addr;
    logic [31:0] data;
    logic [31:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic        ifid_valid;
    logic [15:0] count;

    logic        rst2 = 1'b1;
    logic [15:0] addr2;
    logic [31:0] data2;
    logic [31:0] ifid_instr2;
    logic [15:0] ifid_pc2;
    logic        ifid_valid2;
    logic [15:0] count2;

    int checks = 0;
    int errors = 0;
    bit verbose = 1'b1;

    always #5 clk = ~clk;

    assign data  = 32'hA000_0000 + {16'h0000, addr};
    assign data2 = 32'hA000_0000 + {16'h0000, addr2};

    fetch_stage dut (
        .i_clk(clk), .i_reset(rst), .o_instruction_address(addr),
        .i_instruction_data(data), .i_stall(stall), .i_flush(flush),
        .i_branch_taken(branch), .i_branch_target(target),
        .o_if_id_instruction(ifid_instr), .o_if_id_pc(ifid_pc),
        .o_if_id_valid(ifid_valid), .o_fetch_count(count)
    );

    fetch_stage #(.RESET_PC(16'h0100)) dut2 (
        .i_clk(clk), .i_reset(rst2), .o_instruction_address(addr2),
        .i_instruction_data(data2), .i_stall(1'b0), .i_flush(1'b0),
        .i_branch_taken(1'b0), .i_branch_target(16'h0000),
        .o_if_id_instruction(ifid_instr2), .o_if_id_pc(ifid_pc2),
        .o_if_id_valid(ifid_valid2), .o_fetch_count(count2)
    );

    task automatic step();
        @(posedge clk);
        #1;
        if (verbose)
            $display("t=%0t addr=%h ifid=%h pc=%h v=%b cnt=%h st=%b fl=%b br=%b",
                     $time, addr, ifid_instr, ifid_pc, ifid_valid, count, stall, flush, branch);
    endtask

    task automatic do_reset();
        stall = 0; flush = 0; branch = 0;
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (addr !== 16'h0000 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0 ||
            ifid_pc !== 16'h0 || count !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: addr=%h v=%b instr=%h pc=%h cnt=%h, want 0000/0/0/0/0",
                     addr, ifid_valid, ifid_instr, ifid_pc, count);
        end
        step();
        rst = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (ifid_instr !== 32'hA000_0000 + k || ifid_pc !== 16'(k) || ifid_valid !== 1'b1) begin
                errors++;
                $display("FAIL seq_fetch[%0d]: instr=%h pc=%h v=%b, want %h/%h/1",
                         k, ifid_instr, ifid_pc, ifid_valid, 32'hA000_0000 + k, 16'(k));
            end
        end
        checks++;
        if (count !== 16'd4) begin
            errors++;
            $display("FAIL seq_count: got %h want 0004", count);
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int k = 0; k < 5; k++) step();
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (addr !== 16'd5 || ifid_instr !== 32'hA000_0004 || ifid_pc !== 16'd4 ||
                ifid_valid !== 1'b1 || count !== 16'd5) begin
                errors++;
                $display("FAIL stall_hold[%0d]: addr=%h instr=%h pc=%h v=%b cnt=%h, want 0005/a0000004/0004/1/0005",
                         k, addr, ifid_instr, ifid_pc, ifid_valid, count);
            end
        end
        stall = 0;
        step();
        checks++;
        if (ifid_instr !== 32'hA000_0005 || ifid_pc !== 16'd5 || count !== 16'd6) begin
            errors++;
            $display("FAIL stall_release: instr=%h pc=%h cnt=%h, want a0000005/0005/0006",
                     ifid_instr, ifid_pc, count);
        end
    endtask

    task automatic test_branch();
        do_reset();
        for (int k = 0; k < 8; k++) step();
        branch = 1; target = 16'h0040; stall = 1;
        step();
        branch = 0; stall = 0;
        checks++;
        if (addr !== 16'h0040 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0 ||
            ifid_pc !== 16'h0 || count !== 16'd8) begin
            errors++;
            $display("FAIL branch_bubble: addr=%h v=%b instr=%h pc=%h cnt=%h, want 0040/0/0/0/0008",
                     addr, ifid_valid, ifid_instr, ifid_pc, count);
        end
        step();
        checks++;
        if (ifid_instr !== 32'hA000_0040 || ifid_pc !== 16'h0040 || ifid_valid !== 1'b1 ||
            addr !== 16'h0041 || count !== 16'd9) begin
            errors++;
            $display("FAIL branch_target: instr=%h pc=%h v=%b addr=%h cnt=%h, want a0000040/0040/1/0041/0009",
                     ifid_instr, ifid_pc, ifid_valid, addr, count);
        end
    endtask

    task automatic test_flush();
        for (int s = 0; s < 2; s++) begin
            do_reset();
            for (int k = 0; k < 3; k++) step();
            flush = 1; stall = s[0];
            step();
            flush = 0; stall = 0;
            checks++;
            if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || count !== 16'd3 ||
                addr !== (s == 0 ? 16'd4 : 16'd3)) begin
                errors++;
                $display("FAIL flush_bubble[stall=%0d]: v=%b instr=%h cnt=%h addr=%h, want 0/0/0003/%h",
                         s, ifid_valid, ifid_instr, count, addr, (s == 0 ? 16'd4 : 16'd3));
            end
            step();
            checks++;
            if (ifid_instr !== (s == 0 ? 32'hA000_0004 : 32'hA000_0003) ||
                ifid_pc !== (s == 0 ? 16'd4 : 16'd3) || ifid_valid !== 1'b1 || count !== 16'd4) begin
                errors++;
                $display("FAIL flush_resume[stall=%0d]: instr=%h pc=%h v=%b cnt=%h, want pc %h cnt 0004",
                         s, ifid_instr, ifid_pc, ifid_valid, count, (s == 0 ? 16'd4 : 16'd3));
            end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_pc [4];
        exp_pc[0] = 16'hFFFE; exp_pc[1] = 16'hFFFF; exp_pc[2] = 16'h0000; exp_pc[3] = 16'h0001;
        branch = 1; target = 16'hFFFE;
        step();
        branch = 0;
        checks++;
        if (addr !== 16'hFFFE) begin
            errors++;
            $display("FAIL wrap_redirect: addr=%h want fffe", addr);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (ifid_pc !== exp_pc[k] || ifid_instr !== 32'hA000_0000 + {16'h0, exp_pc[k]} ||
                ifid_valid !== 1'b1) begin
                errors++;
                $display("FAIL wrap_pc[%0d]: pc=%h instr=%h v=%b, want %h", k, ifid_pc, ifid_instr,
                         ifid_valid, exp_pc[k]);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        verbose = 0;
        for (int i = 1; i <= 70000; i++) begin
            step();
            if (i == 65534) begin
                checks++;
                if (count !== 16'hFFFE) begin
                    errors++;
                    $display("FAIL sat_before: cnt=%h want fffe", count);
                end
            end
            if (i == 65535 || i == 70000) begin
                checks++;
                if (count !== 16'hFFFF) begin
                    errors++;
                    $display("FAIL sat_hold[%0d]: cnt=%h want ffff", i, count);
                end
            end
        end
        verbose = 1;
    endtask

    task automatic test_async_reset();
        rst2 = 0;
        for (int k = 0; k < 3; k++) step();
        checks++;
        if (ifid_pc2 !== 16'h0102 || count2 !== 16'd3) begin
            errors++;
            $display("FAIL rst_vec_stream: pc=%h cnt=%h want 0102/0003", ifid_pc2, count2);
        end
        #3;
        rst = 1; rst2 = 1;
        #1;
        checks++;
        if (addr !== 16'h0 || ifid_instr !== 32'h0 || ifid_pc !== 16'h0 ||
            ifid_valid !== 1'b0 || count !== 16'h0) begin
            errors++;
            $display("FAIL async_reset: addr=%h instr=%h pc=%h v=%b cnt=%h, want all 0",
                     addr, ifid_instr, ifid_pc, ifid_valid, count);
        end
        checks++;
        if (addr2 !== 16'h0100 || ifid_instr2 !== 32'h0 || ifid_pc2 !== 16'h0 ||
            ifid_valid2 !== 1'b0 || count2 !== 16'h0) begin
            errors++;
            $display("FAIL async_reset_vec: addr=%h instr=%h pc=%h v=%b cnt=%h, want 0100/0/0/0/0",
                     addr2, ifid_instr2, ifid_pc2, ifid_valid2, count2);
        end
        step();
        rst = 0; rst2 = 0;
        step();
        checks++;
        if (ifid_pc2 !== 16'h0100 || ifid_instr2 !== 32'hA000_0100 || ifid_valid2 !== 1'b1 ||
            count2 !== 16'd1) begin
            errors++;
            $display("FAIL rst_vec_restart: pc=%h instr=%h v=%b cnt=%h, want 0100/a0000100/1/0001",
                     ifid_pc2, ifid_instr2, ifid_valid2, count2);
        end
        checks++;
        if (ifid_pc !== 16'h0000 || ifid_instr !== 32'hA000_0000 || count !== 16'd1) begin
            errors++;
            $display("FAIL rst_restart: pc=%h instr=%h cnt=%h, want 0000/a0000000/0001",
                     ifid_pc, ifid_instr, count);
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_branch();
        test_flush();
        test_wrap();
        test_saturation();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the pipelined CPU. Owns the program counter and drives the instruction memory port: `o_instruction_address` (16-bit word address) and `i_instruction_data` (32-bit). Each cycle it captures the fetched word and its PC into the IF/ID pipeline register that feeds the decode stage. It honours stall, flush and branch-redirect requests coming back from later stages.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset; first address fetched.
- NOP_INSTRUCTION, 32'h0000_0000, encoding placed in IF/ID when a bubble is inserted.

Ports:
- i_clk  in  1  single clock, all state on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- o_instruction_address  out  16  current PC (word address) to instruction memory.
- i_instruction_data  in  32  instruction word, combinational read of o_instruction_address in the same cycle.
- i_stall  in  1  hold PC and IF/ID contents.
- i_flush  in  1  replace IF/ID contents with a bubble.
- i_branch_taken  in  1  redirect PC to i_branch_target.
- i_branch_target  in  16  redirect address.
- o_if_id_instruction  out  32  registered instruction to decode.
- o_if_id_pc  out  16  registered PC of o_if_id_instruction.
- o_if_id_valid  out  1  IF/ID holds a real instruction.
- o_fetch_count  out  16  count of valid instructions delivered into IF/ID, saturating.

## Operation
- State: PC register (16), IF/ID register {instruction, pc, valid}, fetch counter (16). There is no FSM beyond this.
- o_instruction_address = PC at all times. Memory data is consumed in the same cycle.
- Per-edge priority, highest first:
  1. **Reset.** PC = RESET_PC; IF/ID = {NOP_INSTRUCTION, 16'h0000, 0}; count = 0.
  2. **i_branch_taken.** PC = i_branch_target; IF/ID = bubble {NOP_INSTRUCTION, 16'h0000, 0}. This overrides i_stall and i_flush. Count unchanged.
  3. **i_flush (no branch).** IF/ID = bubble.
     - If i_stall = 1, PC holds.
     - If i_stall = 0, PC = PC+1; the word fetched this cycle is discarded.
     - Count unchanged.
  4. **i_stall.** PC, IF/ID and count all hold.
  5. **Normal.** IF/ID = {i_instruction_data, PC, 1}; PC = PC+1; count = count+1, saturating at 16'hFFFF.
- PC increment is modulo 2^16: 16'hFFFF+1 = 16'h0000, with no flag raised.
- i_branch_target is taken verbatim, with no alignment or range check.
- The counter never wraps. Once it reaches 16'hFFFF it stays there until reset.

## Timing
- Reset is asynchronous. Outputs take reset values immediately on i_reset rising, with no clock needed:
  - o_instruction_address = RESET_PC
  - o_if_id_instruction = NOP_INSTRUCTION
  - o_if_id_pc = 0
  - o_if_id_valid = 0
  - o_fetch_count = 0
- Reset removal is synchronous to i_clk; the first fetch edge is the first rising edge with i_reset low.
- Reset asserted mid-stream discards the IF/ID contents and PC immediately. No partial state survives.
- Fetch latency: the word at address A appears on o_if_id_instruction one edge after PC = A, with no stall.
- Branch penalty: with a redirect sampled at edge N, the target is presented on the address bus after N. Its instruction reaches IF/ID after edge N+1; IF/ID shows a bubble between N and N+1.
- All outputs are registered except o_instruction_address, which is a direct register output (no combinational input path).
- Control inputs are sampled only at rising edges. Glitches between edges have no effect.

## Test plan
- **Reset and sequential fetch.** Memory word[k] = 32'hA000_0000+k; hold reset, then release.
  - During reset: address = 0, valid = 0.
  - After edges 1..4: IF/ID = (A0000000, pc 0), (A0000001, 1), (A0000002, 2), (A0000003, 3); count = 4.
- **Stall hold.** Stream from PC 0; assert i_stall for 3 cycles at PC = 5.
  - Address stays 5; IF/ID stays (A0000004, 4); count frozen.
  - After release, the next IF/ID is (A0000005, 5).
- **Branch redirect.** At PC = 8, pulse i_branch_taken with target 16'h0040 while i_stall = 1.
  - Next cycle: address = 0x0040, valid = 0.
  - Following edge: IF/ID = (A0000040, 0x40, 1).
- **Flush.** At PC = 3, pulse i_flush with i_stall = 0.
  - IF/ID valid = 0; address = 4; count unchanged; next IF/ID = (A0000004, 4).
  - Repeat with i_stall = 1: address stays 3.
- **Wrap and saturation.**
  - Branch to 16'hFFFE and run: IF/ID pcs FFFE, FFFF, 0000, 0001.
  - Run 70000 unstalled fetches: o_fetch_count = 16'hFFFF and stays.
- **Asynchronous reset mid-stream.** Raise i_reset between clock edges while streaming.
  - Outputs go to reset values before the next edge.
  - After release, fetch restarts at RESET_PC (parameter overridden to 16'h0100: first IF/ID pc = 0x0100).
